adder_nbit_pipe: RTL
====================

# adder_nbit_pipe

Pipelined, parametrised N-bit add/subtract unit that splits the carry chain into SEG-bit segments, one register stage per segment. It accepts one operation per cycle and produces sum, carry-out and signed overflow a fixed number of cycles later. Backpressure is supported through a valid/ready handshake. It is the clocked successor to the combinational N-bit adder family and is intended for wide datapaths where a full ripple chain does not meet timing.

## Interface
- N, 16: operand/result width; must be a multiple of SEG.
- SEG, 4: bits added per pipeline stage; STAGES = N/SEG. SEG = N gives a single-stage adder.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation present on x/y/c_in/sub.
- in_ready  output  1  unit can accept an operation this cycle.
- x  input  N  operand A.
- y  input  N  operand B.
- c_in  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: x + y + c_in; 1: x - y - c_in.
- out_valid  output  1  result present on sum/c_out/ovf.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  N  result, modulo 2^N.
- c_out  output  1  raw carry out of the MSB (in sub mode, 1 = no borrow).
- ovf  output  1  two's-complement overflow.

## Operation
- Operand conditioning at input:
  - Effective B = sub ? ~y : y.
  - Stage-0 carry = sub ? ~c_in : c_in.
  - In sub mode the unit therefore computes x + ~y + ~c_in, which equals x - y - c_in.
- Stage k (0..STAGES-1):
  - Adds segment k of A and effective B (bits [k*SEG +: SEG]) plus the carry registered by stage k-1.
  - Registers the SEG-bit partial sum, the carry out, and the not-yet-added upper operand segments (skew registers).
  - Lower, already-computed sum bits travel forward unchanged.
  - Each stage carries its own valid bit.
- Final stage register drives the outputs:
  - sum = concatenated partial sums.
  - c_out = carry out of bit N-1.
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
- Flow control uses one global advance enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage shifts forward one position and the input is captured if in_valid = 1.
  - When adv = 0, all stage registers, including valid bits, hold.
  - in_ready = adv; an operation is accepted iff in_valid && in_ready.
  - Bubbles (in_valid = 0 while in_ready = 1) propagate as invalid slots. They are not compressed.
- x, y, c_in and sub are ignored when the operation is not accepted.

## Timing
- Reset (rst = 1 at a clock edge):
  - All valid bits clear.
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 during and after reset (out_valid = 0).
  - Operations in flight when reset is asserted are discarded; no partial result appears afterwards.
- Latency:
  - An operation accepted at edge t appears with out_valid = 1 after edge t + STAGES - 1 (visible in the cycle following that edge), provided no stall occurs.
  - For N = 16, SEG = 4: accepted at edge 0, result valid after edge 3.
  - Each stall cycle (adv = 0) adds exactly one cycle of latency to every in-flight operation.
- Throughput: one operation per cycle while out_ready stays 1.
- out_valid, sum, c_out and ovf remain stable while out_valid = 1 and out_ready = 0.
- When out_valid = 1 and out_ready = 1, a new result may appear in the same edge that retires the current one.
- Simultaneous events:
  - rst overrides in_valid and out_ready.
  - An accept and a retire in the same cycle are both legal.
- Boundary widths:
  - Carry wraps modulo 2^N; no saturation.
  - SEG = N is legal (latency 1).
  - An N/SEG that is not an integer is a configuration error and is flagged by an elaboration-time check.

## Test plan
All cases use N = 16, SEG = 4 unless stated otherwise.

- Reset/idle:
  - Stimulus: assert rst for 2 cycles with in_valid = 1.
  - Required: out_valid = 0, sum = 0, c_out = 0, ovf = 0, in_ready = 1. No output appears for 6 cycles after release with in_valid = 0.
- Add, full carry ripple:
  - Stimulus: x = 0xFFFF, y = 0x0001, c_in = 0, sub = 0.
  - Required: 4 cycles later, sum = 0x0000, c_out = 1, ovf = 0.
  - Stimulus: x = 0x7FFF, y = 0x0001, c_in = 0.
  - Required: sum = 0x8000, c_out = 0, ovf = 1.
- Subtract:
  - Stimulus: x = 0x0005, y = 0x0007, c_in = 0, sub = 1.
  - Required: sum = 0xFFFE, c_out = 0, ovf = 0.
  - Stimulus: x = 0x8000, y = 0x0001, c_in = 0, sub = 1.
  - Required: sum = 0x7FFF, c_out = 1, ovf = 1.
  - Stimulus: x = 0x0010, y = 0x0003, c_in = 1, sub = 1.
  - Required: sum = 0x000C, c_out = 1.
- Streaming:
  - Stimulus: 100 back-to-back random operations with out_ready = 1.
  - Required: one result per cycle, in order, each matching the reference model, with out_valid continuously 1 from cycle 4 through cycle 103.
- Backpressure:
  - Stimulus: random in_valid and random out_ready.
  - Required: no result lost or duplicated; outputs held stable while stalled; in_ready = 0 exactly when out_valid = 1 and out_ready = 0.
- Reset mid-stream and parameter sweep:
  - Stimulus: assert rst while 3 operations are in flight.
  - Required: none of them emerges.
  - Repeat the add/subtract checks with (N = 8, SEG = 8) and (N = 32, SEG = 8), with latencies 1 and 4 respectively.

Source files
------------

// File: rtl/adder_nbit_pipe.sv
// Pipelined N-bit add/subtract: the carry chain is cut into SEG-bit segments,
// one register stage per segment, with a single global advance enable for flow control.
module adder_nbit_pipe #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int STAGES = N / SEG;

  generate
    if (SEG < 1 || (N % SEG) != 0) begin : g_cfg_err
      $error("adder_nbit_pipe: N must be a positive multiple of SEG");
    end
  endgenerate

  // Handshake: an input is taken iff in_valid && in_ready; a result retires iff
  // out_valid && out_ready. in_ready is the global advance enable: the whole pipe
  // (data and valid bits) shifts when the last slot is empty or being consumed,
  // otherwise every stage holds.
  logic adv;

  logic         valid_q [STAGES];
  logic         valid_d [STAGES];
  logic         carry_q [STAGES];
  logic         carry_d [STAGES];
  logic [N-1:0] a_q     [STAGES];
  logic [N-1:0] a_d     [STAGES];
  logic [N-1:0] b_q     [STAGES];
  logic [N-1:0] b_d     [STAGES];
  logic [N-1:0] sum_q   [STAGES];
  logic [N-1:0] sum_d   [STAGES];
  logic         ovf_q;
  logic         ovf_d;

  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic [N-1:0] src_sum;
  logic         src_c;
  logic         src_v;
  logic [SEG:0] seg_res;

  assign adv = !valid_q[STAGES-1] || out_ready;

  // Operands shift right by SEG each stage so every stage adds the low segment;
  // finished sum bits enter at the top and shift down into final position.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    seg_res = '0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          src_a   = x;
          src_b   = sub ? ~y : y;
          src_c   = sub ^ c_in;
          src_sum = '0;
          src_v   = in_valid;
        end else begin
          src_a   = a_q[k-1];
          src_b   = b_q[k-1];
          src_c   = carry_q[k-1];
          src_sum = sum_q[k-1];
          src_v   = valid_q[k-1];
        end
        seg_res    = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, src_c};
        a_d[k]     = src_a >> SEG;
        b_d[k]     = src_b >> SEG;
        sum_d[k]   = (src_sum >> SEG) | (N'(seg_res[SEG-1:0]) << (N - SEG));
        carry_d[k] = seg_res[SEG];
        valid_d[k] = src_v;
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        if (k == STAGES - 1) begin
          ovf_d = seg_res[SEG] ^ seg_res[SEG-1] ^ src_a[SEG-1] ^ src_b[SEG-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
